arbitro_ram64: RTL

Two-requester round-robin arbiter and access sequencer for the 64-word × 16-bit RAM (`minha_ram64`). It accepts read or write requests from two independent masters, for example a program counter fetch path and a data path, over a req/ack handshake. It serialises the requests onto the single RAM port and returns read data in a register. The RAM instance lives inside this block, so the masters never drive the RAM directly.

---
 rtl/arbitro_ram64_pkg.sv | 14 +
 rtl/arbitro_ram64_if.sv | 33 +++
 rtl/minha_ram64.sv | 23 ++
 rtl/arbitro_ram64.sv | 120 ++++++++++++
 4 files changed

// File: rtl/arbitro_ram64_pkg.sv
// rtl/arbitro_ram64_pkg.sv - shared state encodings and width constants for arbitro_ram64
package arbitro_ram64_pkg;

  localparam int LARGURA_PADRAO  = 16;
  localparam int END_BITS_PADRAO = 6;
  localparam int PALAVRAS_PADRAO = 1 << END_BITS_PADRAO;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

endpackage

// File: rtl/arbitro_ram64_if.sv
// rtl/arbitro_ram64_if.sv - request/ack bus between the two masters and arbitro_ram64
interface arbitro_ram64_if
  import arbitro_ram64_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int END_BITS = END_BITS_PADRAO
);

  logic                req0;
  logic                req1;
  logic                we0;
  logic                we1;
  logic [END_BITS-1:0] end0;
  logic [END_BITS-1:0] end1;
  logic [LARGURA-1:0]  din0;
  logic [LARGURA-1:0]  din1;
  logic                ack0;
  logic                ack1;
  logic [LARGURA-1:0]  dout0;
  logic [LARGURA-1:0]  dout1;
  logic                ocupado;

  modport master (
    output req0, req1, we0, we1, end0, end1, din0, din1,
    input  ack0, ack1, dout0, dout1, ocupado
  );

  modport slave (
    input  req0, req1, we0, we1, end0, end1, din0, din1,
    output ack0, ack1, dout0, dout1, ocupado
  );

endinterface

// File: rtl/minha_ram64.sv
// rtl/minha_ram64.sv - single-port RAM, synchronous write and combinational read, no reset
module minha_ram64 #(
  parameter int LARGURA  = 16,
  parameter int END_BITS = 6
) (
  input  logic                clock,
  input  logic                controle_write,
  input  logic [END_BITS-1:0] endereco,
  input  logic [LARGURA-1:0]  dados_entrada,
  output logic [LARGURA-1:0]  dados_saida
);

  logic [LARGURA-1:0] mem [1 << END_BITS];

  always_ff @(posedge clock) begin
    if (controle_write) begin
      mem[endereco] <= dados_entrada;
    end
  end

  assign dados_saida = mem[endereco];

endmodule

// File: rtl/arbitro_ram64.sv
// rtl/arbitro_ram64.sv - two-master round-robin arbiter sequencing accesses onto minha_ram64
module arbitro_ram64
  import arbitro_ram64_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int END_BITS = END_BITS_PADRAO
) (
  input  logic          clock_principal,
  input  logic          reset,
  arbitro_ram64_if.slave bus
);

  estado_t             estado;
  estado_t             prox_estado;
  logic                prio;
  logic                conceder;
  logic                ind_escolhido;
  logic                g_ind;
  logic                g_we;
  logic [END_BITS-1:0] g_end;
  logic [LARGURA-1:0]  g_din;
  logic                controle_write;
  logic [LARGURA-1:0]  ram_q;
  logic                ack0_r;
  logic                ack1_r;
  logic [LARGURA-1:0]  dout0_r;
  logic [LARGURA-1:0]  dout1_r;

  always_ff @(posedge clock_principal or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado   = estado;
    conceder      = 1'b0;
    ind_escolhido = 1'b0;
    // prio only breaks ties; a lone request wins regardless of the pointer
    if (bus.req0 && bus.req1) begin
      ind_escolhido = prio;
    end else begin
      ind_escolhido = bus.req1;
    end
    case (estado)
      OCIOSO: begin
        if (bus.req0 || bus.req1) begin
          conceder    = 1'b1;
          prox_estado = ACESSO;
        end
      end
      ACESSO:   prox_estado = RESPOSTA;
      RESPOSTA: prox_estado = OCIOSO;
      default:  prox_estado = OCIOSO;
    endcase
  end

  // Request fields are frozen at grant so later changes by the master cannot leak into the access
  always_ff @(posedge clock_principal or posedge reset) begin
    if (reset) begin
      g_ind <= 1'b0;
      g_we  <= 1'b0;
      g_end <= '0;
      g_din <= '0;
    end else if (conceder) begin
      g_ind <= ind_escolhido;
      g_we  <= ind_escolhido ? bus.we1  : bus.we0;
      g_end <= ind_escolhido ? bus.end1 : bus.end0;
      g_din <= ind_escolhido ? bus.din1 : bus.din0;
    end
  end

  always_ff @(posedge clock_principal or posedge reset) begin
    if (reset) begin
      prio    <= 1'b0;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      dout0_r <= '0;
      dout1_r <= '0;
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      if (estado == ACESSO) begin
        prio   <= ~g_ind;
        ack0_r <= ~g_ind;
        ack1_r <= g_ind;
        if (!g_we) begin
          if (g_ind) begin
            dout1_r <= ram_q;
          end else begin
            dout0_r <= ram_q;
          end
        end
      end
    end
  end

  // Decoded from the state register so an asynchronous reset removes the write at once
  assign controle_write = (estado == ACESSO) && g_we;

  minha_ram64 #(
    .LARGURA  (LARGURA),
    .END_BITS (END_BITS)
  ) u_ram (
    .clock          (clock_principal),
    .controle_write (controle_write),
    .endereco       (g_end),
    .dados_entrada  (g_din),
    .dados_saida    (ram_q)
  );

  assign bus.ack0    = ack0_r;
  assign bus.ack1    = ack1_r;
  assign bus.dout0   = dout0_r;
  assign bus.dout1   = dout1_r;
  assign bus.ocupado = (estado != OCIOSO);

endmodule
